// File: rtl/binarization_stream_ctrl.sv
// Thermometer binarization front end for the first BNN layer.
// Two-entry ping-pong chunk buffer, one channel bitplane out per beat.
module binarization_stream_ctrl #(
    parameter int PARAM_IN_CNT = 784,
    parameter int PARAM_IN_BIT = 2,
    parameter int PARAM_CH_CNT = 2 ** PARAM_IN_BIT,
    parameter int PARAM_CHUNK  = 16,
    localparam int NCHUNK = PARAM_IN_CNT / PARAM_CHUNK,
    localparam int CH_W   = (PARAM_CH_CNT > 1) ? $clog2(PARAM_CH_CNT) : 1,
    localparam int CK_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PARAM_CHUNK*PARAM_IN_BIT-1:0]  in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PARAM_CHUNK-1:0]               out_data,
    output logic [CH_W-1:0]                      out_ch,
    output logic [CK_W-1:0]                      out_chunk,
    output logic                                 out_last
);

    localparam int ENT_W = PARAM_CHUNK * PARAM_CH_CNT;
    localparam int IC_W  = $clog2(NCHUNK + 1);

    if (PARAM_IN_CNT % PARAM_CHUNK != 0) begin : g_cfg_chk
        $error("PARAM_IN_CNT must be a multiple of PARAM_CHUNK");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0] buf_q [2];
    logic [1:0]       count;
    logic             wptr, rptr;
    logic [IC_W-1:0]  in_cnt;
    logic [CK_W-1:0]  chunk_q;
    logic [CH_W-1:0]  ch_q;
    logic             done_q;

    logic push, out_fire, ch_end, pop, fin;

    // Entry layout is channel-major so a bitplane is one contiguous slice.
    function automatic logic [ENT_W-1:0] encode(
        input logic [PARAM_CHUNK*PARAM_IN_BIT-1:0] d
    );
        logic [PARAM_IN_BIT:0]        sx;
        logic signed [PARAM_IN_BIT:0] ones;
        encode = '0;
        for (int i = 0; i < PARAM_CHUNK; i++) begin
            sx   = {d[i*PARAM_IN_BIT+PARAM_IN_BIT-1],
                    d[i*PARAM_IN_BIT +: PARAM_IN_BIT]};
            ones = $signed(sx + (PARAM_IN_BIT+1)'(PARAM_CH_CNT / 2));
            for (int c = 0; c < PARAM_CH_CNT; c++) begin
                encode[c*PARAM_CHUNK+i] = (ones > $signed((PARAM_IN_BIT+1)'(c)));
            end
        end
    endfunction

    assign busy      = (state == RUN);
    assign done      = done_q;
    assign in_ready  = busy && (count < 2'd2) && (in_cnt < IC_W'(NCHUNK));
    assign out_valid = (count != 2'd0);
    assign out_ch    = ch_q;
    assign out_chunk = chunk_q;
    assign ch_end    = (ch_q == CH_W'(PARAM_CH_CNT - 1));
    assign out_last  = out_valid && ch_end && (chunk_q == CK_W'(NCHUNK - 1));
    assign out_data  = out_valid ? buf_q[rptr][ch_q*PARAM_CHUNK +: PARAM_CHUNK]
                                 : '0;

    assign push     = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign pop      = out_fire && ch_end;
    assign fin      = out_fire && out_last;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (fin)   state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wptr] <= encode(in_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            in_cnt  <= '0;
            chunk_q <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= fin;
            count  <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wptr   <= ~wptr;
                in_cnt <= in_cnt + 1'b1;
            end
            if (pop) begin
                rptr    <= ~rptr;
                chunk_q <= chunk_q + 1'b1;
            end
            if (out_fire) ch_q <= ch_end ? '0 : ch_q + 1'b1;
            // Image complete: rearm counters for the next start.
            if (fin) begin
                in_cnt  <= '0;
                chunk_q <= '0;
                wptr    <= 1'b0;
                rptr    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_binarization_stream_ctrl.sv
// Scoreboard bench for binarization_stream_ctrl.
// Expected bitplanes come from a thermometer model of each accepted chunk.
module tb_binarization_stream_ctrl;

    localparam int CHUNK  = 16;
    localparam int IN_BIT = 2;
    localparam int CH     = 4;
    localparam int NCHUNK = 49;
    localparam int BEATS  = NCHUNK * CH;

    typedef struct {
        logic [CHUNK-1:0] d;
        logic [1:0]       ch;
        logic [5:0]       ck;
        logic             last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst, start, busy, done;
    logic                    in_valid, in_ready;
    logic [CHUNK*IN_BIT-1:0] in_data;
    logic                    out_valid, out_ready;
    logic [CHUNK-1:0]        out_data;
    logic [1:0]              out_ch;
    logic [5:0]              out_chunk;
    logic                    out_last;

    binarization_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_chunk(out_chunk), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t exp_q [$];
    logic [CHUNK*IN_BIT-1:0] img [NCHUNK];
    logic [CHUNK-1:0] out_log [BEATS];
    logic [CHUNK-1:0] log_a [BEATS];
    int beat_cnt, last_cnt, done_cnt, model_chunk;
    int ready_mode;
    bit last_prev, have_prev;
    logic [CHUNK-1:0] p_data;
    logic [1:0] p_ch;
    logic [5:0] p_ck;
    logic p_last;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pixel p lights the lowest CH/2+p channels.
    function automatic logic [CHUNK-1:0] plane(
        input logic [CHUNK*IN_BIT-1:0] w, input int c
    );
        logic signed [IN_BIT-1:0] s;
        int p;
        plane = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = w[i*IN_BIT +: IN_BIT];
            p = s;
            plane[i] = ((CH / 2 + p) > c);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_prev   = 0;
            have_prev   = 0;
            model_chunk = 0;
        end else begin
            chk("done", done, last_prev);
            if (last_prev) chk("busy_after_last", busy, 0);
            last_prev = 0;
            if (done) done_cnt++;
            if (have_prev) begin
                chk("stall_data", out_data, p_data);
                chk("stall_ch", out_ch, p_ch);
                chk("stall_chunk", out_chunk, p_ck);
                chk("stall_last", out_last, p_last);
            end
            have_prev = out_valid && !out_ready;
            p_data = out_data; p_ch = out_ch; p_ck = out_chunk; p_last = out_last;
            if (in_valid && in_ready) begin
                for (int c = 0; c < CH; c++) begin
                    beat_t b;
                    b.d = plane(in_data, c);
                    b.ch = 2'(c);
                    b.ck = 6'(model_chunk);
                    b.last = (model_chunk == NCHUNK - 1) && (c == CH - 1);
                    exp_q.push_back(b);
                end
                model_chunk = (model_chunk + 1) % NCHUNK;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_ch", out_ch, e.ch);
                    chk("out_chunk", out_chunk, e.ck);
                    chk("out_last", out_last, e.last);
                end
                if (beat_cnt < BEATS) out_log[beat_cnt] = out_data;
                beat_cnt++;
                if (out_last) begin
                    last_cnt++;
                    last_prev = 1;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_counts();
        beat_cnt = 0; last_cnt = 0; done_cnt = 0;
    endtask

    task automatic start_image();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_on_start", busy, 1);
        chk("in_ready_on_start", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_pct,
                              input int max_cyc, input bit start_noise,
                              output int next);
        int k = lo;
        int cyc = 0;
        while (k < hi && cyc < max_cyc) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? img[k] : CHUNK*IN_BIT'($urandom);
            start    = start_noise && ($urandom_range(7) == 0);
            @(negedge clk);
            if (start) chk("busy_start_in_run", busy, 1);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        next     = k;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", (n < 3000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic image_checks();
        chk("beat_count", beat_cnt, BEATS);
        chk("last_count", last_cnt, 1);
        chk("done_count", done_cnt, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    task automatic rand_img();
        for (int k = 0; k < NCHUNK; k++) img[k] = $urandom;
    endtask

    logic [CHUNK-1:0] lit [12];
    int n, diff;

    initial begin
        lit = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000,
                16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000,
                16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        ready_mode = 0;
        clr_counts();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom);
            start    = 1'($urandom);
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;

        // Image A: directed encoding chunks then random
        rand_img();
        img[0] = 32'h5555_5555;
        img[1] = 32'h2222_2222;
        img[2] = 32'hFFFF_FFFF;
        clr_counts();
        start_image();
        send_range(0, NCHUNK, 0, 2000, 0, n);
        chk("a_accepted", n, NCHUNK);
        wait_done();
        image_checks();
        for (int i = 0; i < 12; i++) chk("encode_lit", out_log[i], lit[i]);
        log_a = out_log;

        // Image A again with gaps, random ready and start noise
        ready_mode = 1;
        clr_counts();
        start_image();
        send_range(0, NCHUNK, 30, 4000, 1, n);
        chk("a2_accepted", n, NCHUNK);
        wait_done();
        image_checks();
        diff = 0;
        for (int i = 0; i < BEATS; i++) if (out_log[i] !== log_a[i]) diff++;
        chk("repeat_identical", diff, 0);

        // Backpressure
        rand_img();
        ready_mode = 2;
        @(posedge clk); #1;
        clr_counts();
        start_image();
        send_range(0, NCHUNK, 0, 12, 0, n);
        chk("stall_accepted", n, 2);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        @(posedge clk); #1;
        ready_mode = 0;
        send_range(n, NCHUNK, 0, 2000, 0, n);
        chk("b_accepted", n, NCHUNK);
        wait_done();
        image_checks();

        // Reset mid-image
        rand_img();
        ready_mode = 1;
        clr_counts();
        start_image();
        send_range(0, 10, 0, 500, 0, n);
        chk("abort_accepted", n, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        rand_img();
        clr_counts();
        start_image();
        send_range(0, NCHUNK, 20, 4000, 0, n);
        chk("c_accepted", n, NCHUNK);
        wait_done();
        image_checks();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
